wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
// - Parametrised register-file writeback stage: selects one of NUM_SRC result sources, aligns and
//   extends load data, and registers result + rd/we for the register unit (MEM/WB boundary).
// - Sits between ALU / data-memory / PC-adder result buses and the register file.
// - Adds valid/ready handshake, stall, flush and illegal-select/misalignment detection.
// PARAMETERS
// - XLEN       32  data width of every source and of ru_wrdata
// - NUM_SRC    4   number of result sources (>=2)
// - SEL_W      2   select width; must satisfy 2**SEL_W >= NUM_SRC
// - LOAD_SRC   1   source index carrying raw data-memory word (load align/extend applied)
// - RADDR_W    5   destination register address width
// PORTS
// - clk        in   1                clock, rising edge
// - rst_n      in   1                synchronous reset, active low
// - in_valid   in   1                upstream result valid
// - in_ready   out  1                stage can accept this cycle
// - src_data   in   NUM_SRC*XLEN     packed sources, src i at [i*XLEN +: XLEN]
// - sel        in   SEL_W            source select
// - byte_off   in   2                load address bits [1:0]
// - ld_funct3  in   3                RV32 load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
// - rd_addr    in   RADDR_W          destination register
// - rd_we      in   1                writeback requested
// - stall      in   1                downstream cannot accept (holds the output register)
// - flush      in   1                kill held and incoming result
// - out_valid  out  1                ru_* fields valid
// - ru_wrdata  out  XLEN             write data to register unit
// - ru_rd      out  RADDR_W          write address
// - ru_we      out  1                write enable (qualified by out_valid)
// - err        out  1                registered error flag for the held result
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): out_valid, ru_wrdata, ru_rd, ru_we and err all 0; reset has priority over everything.
// - in_ready = !out_valid || !stall (combinational); transfer occurs when in_valid && in_ready.
// - Latency 1 cycle: accepted inputs appear on ru_* at the next edge; throughput 1/cycle.
// - Held result: with out_valid && stall, all outputs are frozen and inputs are ignored.
// - Held result retires: with out_valid && !stall and no transfer, out_valid goes to 0.
// - Flush: next state out_valid=0, ru_we=0 and err=0; any concurrent transfer is discarded. Flush beats
//   stall. ru_wrdata/ru_rd are don't-care when out_valid=0.
// - Select: sel<NUM_SRC picks src[sel]. sel>=NUM_SRC gives ru_wrdata=0, ru_we=0, err=1.
// - sel==LOAD_SRC: word w shifted right by 8*byte_off, then:
//   - LB/LBU: sign/zero-extend byte [7:0]
//   - LH/LHU: sign/zero-extend half [15:0]
//   - LW: passthrough
//   - other funct3: ru_wrdata=0, ru_we=0, err=1
// - Misaligned load: LH/LHU with byte_off==3, or LW with byte_off!=0, gives ru_wrdata=0, ru_we=0, err=1.
// - ru_we = rd_we && (rd_addr!=0) && no error; x0 is never written.
// - Pure register stage: no combinational path from src_data to ru_wrdata.
// CONFIGURATION
// - WB_ERR_CNT_EN defined:
//   - adds output err_count[15:0]
//   - increments when a transfer is accepted with an error and without a concurrent flush
//   - saturates at 16'hFFFF; reset to 0 by rst_n only (flush does not clear it)
// - WB_ERR_CNT_EN undefined: no err_count port, no counter logic; all other behaviour identical.
// TESTING
// - Reset then idle: rst_n=0 for 2 cycles -> out_valid=0, ru_we=0, ru_wrdata=0, err=0.
// - Sources: src0=0x11, src1=0x22, src2=0x33, sel=2, rd=5, we=1, then flush/err/stall-free cycle
//   -> next cycle ru_wrdata=0x33, ru_rd=5, ru_we=1, out_valid=1.
// - Loads with word 0x80FF7F01 on LOAD_SRC:
//   - LB off=3 -> 0xFFFFFF80
//   - LBU off=1 -> 0x0000007F
//   - LH off=2 -> 0xFFFF80FF
//   - LW off=2 -> ru_we=0, err=1
// - Stall/flush: accept A, hold stall=1 for 3 cycles with new in_valid -> outputs stay A, in_ready=0;
//   then flush=1 -> out_valid=0.
// - Illegal select and x0:
//   - sel=3 with NUM_SRC=3 -> ru_wrdata=0, err=1, err_count +1 (WB_ERR_CNT_EN)
//   - rd=0, we=1 -> ru_we=0

Source files
------------

// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM/WB writeback select stage.
// Picks one of NUM_SRC result sources. Load data from LOAD_SRC is aligned and
// extended here. The result, with rd/we, is registered for the register file.
// A valid/ready handshake connects the stage upstream. Stall holds the output
// register, and flush kills both the held result and any incoming one.
//
// Optional feature: define WB_ERR_CNT_EN to add the saturating err_count output.
//
// Ports:
//   clk, rst_n    clock (rising edge), synchronous active-low reset
//   in_valid      upstream result valid
//   in_ready      stage can accept this cycle (combinational)
//   src_data      packed sources, source i at [i*XLEN +: XLEN]
//   sel           source select
//   byte_off      load address bits [1:0]
//   ld_funct3     RV32 load funct3
//   rd_addr       destination register
//   rd_we         writeback requested
//   stall         downstream cannot accept; hold output register
//   flush         kill held and incoming result
//   out_valid     ru_* fields valid
//   ru_wrdata     register-file write data
//   ru_rd         register-file write address
//   ru_we         register-file write enable (qualified by out_valid)
//   err           error flag for the held result
//   err_count     (WB_ERR_CNT_EN only) saturating count of accepted errors
module wb_select_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned LOAD_SRC = 1,
    parameter int unsigned RADDR_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              byte_off,
    input  logic [2:0]              ld_funct3,
    input  logic [RADDR_W-1:0]      rd_addr,
    input  logic                    rd_we,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [XLEN-1:0]         ru_wrdata,
    output logic [RADDR_W-1:0]      ru_rd,
    output logic                    ru_we,
    output logic                    err
`ifdef WB_ERR_CNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic            transfer;
    logic [XLEN-1:0] sel_word;
    logic            sel_ok;
    logic            is_load;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_data;
    logic            ld_err;
    logic            err_next;
    logic [XLEN-1:0] data_next;
    logic            we_next;

    // A stalled held result blocks new input; an empty or draining stage accepts.
    assign in_ready = !out_valid || !stall;
    assign transfer = in_valid && in_ready;

    // Source mux; out-of-range selects leave sel_ok low.
    always_comb begin
        sel_word = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word = src_data[i*XLEN +: XLEN];
                sel_ok   = 1'b1;
            end
        end
    end

    assign is_load    = sel_ok && (sel == SEL_W'(LOAD_SRC));
    assign ld_shifted = sel_word >> {byte_off, 3'b000};

    // Load alignment/extension and funct3 / misalignment checking.
    always_comb begin
        ld_data = '0;
        ld_err  = 1'b0;
        unique case (ld_funct3)
            F3_LB:  ld_data = {{(XLEN-BYTE_W){ld_shifted[BYTE_W-1]}}, ld_shifted[BYTE_W-1:0]};
            F3_LBU: ld_data = {{(XLEN-BYTE_W){1'b0}}, ld_shifted[BYTE_W-1:0]};
            F3_LH: begin
                ld_err  = (byte_off == 2'd3);
                ld_data = {{(XLEN-HALF_W){ld_shifted[HALF_W-1]}}, ld_shifted[HALF_W-1:0]};
            end
            F3_LHU: begin
                ld_err  = (byte_off == 2'd3);
                ld_data = {{(XLEN-HALF_W){1'b0}}, ld_shifted[HALF_W-1:0]};
            end
            F3_LW: begin
                ld_err  = (byte_off != 2'd0);
                ld_data = sel_word;
            end
            default: ld_err = 1'b1;
        endcase
    end

    // Next result; any error forces zero data and suppresses the write. x0 is never written.
    always_comb begin
        err_next  = !sel_ok || (is_load && ld_err);
        data_next = '0;
        if (!err_next) begin
            data_next = is_load ? ld_data : sel_word;
        end
        we_next = rd_we && (rd_addr != '0) && !err_next;
    end

    // Output register: reset > flush > stall-hold > transfer > retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ru_wrdata <= '0;
            ru_rd     <= '0;
            ru_we     <= 1'b0;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ru_we     <= 1'b0;
            err       <= 1'b0;
        end else if (out_valid && stall) begin
            out_valid <= out_valid;
        end else if (transfer) begin
            out_valid <= 1'b1;
            ru_wrdata <= data_next;
            ru_rd     <= rd_addr;
            ru_we     <= we_next;
            err       <= err_next;
        end else begin
            out_valid <= 1'b0;
            ru_we     <= 1'b0;
            err       <= 1'b0;
        end
    end

`ifdef WB_ERR_CNT_EN
    // Saturating count of accepted erroneous results; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (transfer && !flush && err_next && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_SRC  = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned LOAD_SRC = 1;
    localparam int unsigned RADDR_W  = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [SEL_W-1:0]        sel;
    logic [1:0]              byte_off;
    logic [2:0]              ld_funct3;
    logic [RADDR_W-1:0]      rd_addr;
    logic                    rd_we;
    logic                    stall;
    logic                    flush;
    logic                    out_valid;
    logic [XLEN-1:0]         ru_wrdata;
    logic [RADDR_W-1:0]      ru_rd;
    logic                    ru_we;
    logic                    err;
`ifdef WB_ERR_CNT_EN
    logic [15:0]             err_count;
    logic [15:0]             exp_cnt = '0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_select_stage #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
        .LOAD_SRC(LOAD_SRC), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_data(src_data), .sel(sel), .byte_off(byte_off), .ld_funct3(ld_funct3),
        .rd_addr(rd_addr), .rd_we(rd_we), .stall(stall), .flush(flush),
        .out_valid(out_valid), .ru_wrdata(ru_wrdata), .ru_rd(ru_rd), .ru_we(ru_we),
        .err(err)
`ifdef WB_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    // Reference result for the current inputs (NUM_SRC=3, LOAD_SRC=1).
    function automatic exp_t model(input logic [95:0] srcs, input logic [1:0] s,
                                   input logic [1:0] off, input logic [2:0] f3,
                                   input logic [4:0] rd, input logic w);
        exp_t        e;
        logic [31:0] word;
        logic        bad;
        int          sh;
        e   = '0;
        bad = 1'b0;
        sh  = 8 * int'(off);
        if (s == 2'd3) begin
            bad = 1'b1;
        end else if (s == 2'd1) begin
            word = srcs[63:32];
            case (f3)
                3'b000: e.data = {{24{word[sh+7]}}, word[sh +: 8]};
                3'b100: e.data = {24'h0, word[sh +: 8]};
                3'b001: if (off == 2'd3) bad = 1'b1;
                        else e.data = {{16{word[sh+15]}}, word[sh +: 16]};
                3'b101: if (off == 2'd3) bad = 1'b1;
                        else e.data = {16'h0, word[sh +: 16]};
                3'b010: if (off != 2'd0) bad = 1'b1;
                        else e.data = word;
                default: bad = 1'b1;
            endcase
        end else begin
            e.data = srcs[int'(s)*32 +: 32];
        end
        if (bad) e.data = '0;
        e.err = bad;
        e.we  = w && (rd != 5'd0) && !bad;
        e.rd  = rd;
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] off,
                         input logic [2:0] f3, input logic [4:0] rd, input logic w);
        in_valid  = v;
        sel       = s;
        byte_off  = off;
        ld_funct3 = f3;
        rd_addr   = rd;
        rd_we     = w;
    endtask

    task automatic push_exp();
        sb.push_back(model(src_data, sel, byte_off, ld_funct3, rd_addr, rd_we));
    endtask

    task automatic pop_exp();
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got empty queue, need an entry");
            cur = '0;
        end else begin
            cur = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        src_data = {32'h33, 32'h22, 32'h11};
        drive(1'b1, 2'd0, 2'd0, 3'b010, 5'd1, 1'b1);
        repeat (2) cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_cmp++; if (ru_we !== 1'b0) begin n_fail++; $display("FAIL reset_ru_we: got %b need 0", ru_we); end
        n_cmp++; if (ru_wrdata !== 32'h0) begin n_fail++; $display("FAIL reset_ru_wrdata: got %h need 0", ru_wrdata); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", err); end
`ifdef WB_ERR_CNT_EN
        n_cmp++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count: got %h need 0", err_count); end
`endif
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b need 0", out_valid); end
    endtask

    task automatic test_select();
        logic [1:0] sels [3] = '{2'd2, 2'd0, 2'd2};
        logic [4:0] rds  [3] = '{5'd5, 5'd7, 5'd31};
        src_data = {32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sels[i], 2'd0, 3'b010, rds[i], 1'b1);
            push_exp();
            cycle();
            pop_exp();
            n_cmp++;
            if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, cur}) begin
                n_fail++;
                $display("FAIL select_%0d: got v=%b d=%h rd=%0d we=%b err=%b need d=%h rd=%0d we=%b err=%b",
                         i, out_valid, ru_wrdata, ru_rd, ru_we, err, cur.data, cur.rd, cur.we, cur.err);
            end
        end
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL retire_out_valid: got %b need 0", out_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [10] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b010, 3'b101, 3'b101, 3'b011, 3'b000, 3'b001};
        logic [1:0]  offs [10] = '{2'd3,   2'd1,   2'd2,   2'd2,   2'd0,   2'd0,   2'd3,   2'd0,   2'd0,   2'd1};
        logic [31:0] dats [10] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h0, 32'h80FF7F01,
                                   32'h00007F01, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFF7F};
        logic        errs [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        src_data = {32'h33, 32'h80FF7F01, 32'h11};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd1, offs[i], f3s[i], 5'd3, 1'b1);
            sb.push_back('{data: dats[i], rd: 5'd3, we: !errs[i], err: errs[i]});
            cycle();
            pop_exp();
            n_cmp++;
            if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, cur}) begin
                n_fail++;
                $display("FAIL load_%0d: got v=%b d=%h rd=%0d we=%b err=%b need d=%h rd=%0d we=%b err=%b",
                         i, out_valid, ru_wrdata, ru_rd, ru_we, err, cur.data, cur.rd, cur.we, cur.err);
            end
`ifdef WB_ERR_CNT_EN
            if (errs[i]) exp_cnt++;
`endif
        end
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        cycle();
    endtask

    task automatic test_stall_flush();
        src_data = {32'h33, 32'h22, 32'h11};
        drive(1'b1, 2'd0, 2'd0, 3'b010, 5'd9, 1'b1);
        push_exp();
        cycle();
        pop_exp();
        n_cmp++;
        if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, cur}) begin
            n_fail++;
            $display("FAIL stall_accept_a: got v=%b d=%h rd=%0d need d=%h rd=%0d", out_valid, ru_wrdata, ru_rd, cur.data, cur.rd);
        end
        stall = 1'b1;
        drive(1'b1, 2'd2, 2'd0, 3'b010, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d: got %b need 0", i, in_ready); end
            cycle();
            n_cmp++;
            if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, cur}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b d=%h rd=%0d we=%b need d=%h rd=%0d we=%b",
                         i, out_valid, ru_wrdata, ru_rd, ru_we, cur.data, cur.rd, cur.we);
            end
        end
        flush = 1'b1;
        cycle();
        n_cmp++;
        if ({out_valid, ru_we, err} !== 3'b000) begin
            n_fail++; $display("FAIL flush_over_stall: got v=%b we=%b err=%b need 000", out_valid, ru_we, err);
        end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_in_ready: got %b need 1", in_ready); end
        stall = 1'b0;
        cycle();
        n_cmp++;
        if ({out_valid, ru_we, err} !== 3'b000) begin
            n_fail++; $display("FAIL flush_discard_incoming: got v=%b we=%b err=%b need 000", out_valid, ru_we, err);
        end
        flush = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        cycle();
    endtask

    task automatic test_illegal_x0();
        src_data = {32'h33, 32'h22, 32'h11};
        drive(1'b1, 2'd3, 2'd0, 3'b010, 5'd6, 1'b1);
        push_exp();
        cycle();
        pop_exp();
        n_cmp++;
        if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, 32'h0, 5'd6, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_sel: got v=%b d=%h rd=%0d we=%b err=%b need d=0 rd=6 we=0 err=1",
                     out_valid, ru_wrdata, ru_rd, ru_we, err);
        end
`ifdef WB_ERR_CNT_EN
        exp_cnt++;
        n_cmp++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL err_count_inc: got %h need %h", err_count, exp_cnt); end
`endif
        drive(1'b1, 2'd0, 2'd0, 3'b010, 5'd0, 1'b1);
        push_exp();
        cycle();
        pop_exp();
        n_cmp++;
        if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, 32'h11, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL x0_write: got v=%b d=%h rd=%0d we=%b err=%b need d=11 rd=0 we=0 err=0",
                     out_valid, ru_wrdata, ru_rd, ru_we, err);
        end
        flush = 1'b1;
        drive(1'b1, 2'd3, 2'd0, 3'b010, 5'd6, 1'b1);
        cycle();
        flush = 1'b0;
        n_cmp++;
        if ({out_valid, err} !== 2'b00) begin
            n_fail++; $display("FAIL flushed_error: got v=%b err=%b need 00", out_valid, err);
        end
`ifdef WB_ERR_CNT_EN
        n_cmp++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL err_count_flush: got %h need %h", err_count, exp_cnt); end
`endif
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        cycle();
    endtask

    task automatic test_back_to_back();
        logic mdl_valid = 1'b0;
        logic nxt_valid;
        logic exp_ready;
        logic acc;
        for (int i = 0; i < 400; i++) begin
            src_data = {$urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            exp_ready = !mdl_valid || !stall;
            #1;
            n_cmp++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready_%0d: got %b need %b", i, in_ready, exp_ready); end
            acc = in_valid && exp_ready && !flush;
            if (acc) push_exp();
`ifdef WB_ERR_CNT_EN
            if (acc && model(src_data, sel, byte_off, ld_funct3, rd_addr, rd_we).err && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
            nxt_valid = flush ? 1'b0 : ((mdl_valid && stall) ? 1'b1 : acc);
            cycle();
            if (acc) pop_exp();
            n_cmp++;
            if (nxt_valid) begin
                if ({out_valid, ru_wrdata, ru_rd, ru_we, err} !== {1'b1, cur}) begin
                    n_fail++;
                    $display("FAIL rand_out_%0d: got v=%b d=%h rd=%0d we=%b err=%b need d=%h rd=%0d we=%b err=%b",
                             i, out_valid, ru_wrdata, ru_rd, ru_we, err, cur.data, cur.rd, cur.we, cur.err);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rand_idle_%0d: got v=%b need 0", i, out_valid);
            end
            mdl_valid = nxt_valid;
        end
`ifdef WB_ERR_CNT_EN
        n_cmp++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL rand_err_count: got %h need %h", err_count, exp_cnt); end
`endif
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 3'b010, 5'd0, 1'b0);
        cycle();
    endtask

    initial begin
        test_reset();
        test_select();
        test_loads();
        test_stall_flush();
        test_illegal_x0();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got %0d entries need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
